// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Each byte is loaded, sent with a one-cycle pulse, and tracked until the transmitter is idle again.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16,
  parameter int HOLD_TIMEOUT  = 4096
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_byte,
  output logic                 tx_send,
  input  logic                 tx_idle,
  output logic                 busy,
  output logic                 err_start,
  output logic                 err_hold
);
  localparam int DATA_W = 8;
  localparam int IW     = $clog2(NUM_REQ);
  localparam int TMAX   = (HOLD_TIMEOUT > START_TIMEOUT) ? HOLD_TIMEOUT : START_TIMEOUT;
  localparam int CW     = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, WAIT_DONE, HOLD} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       owner, owner_nxt;
  logic [IW-1:0]       ptr, ptr_nxt;
  logic                last_q, last_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [NUM_REQ-1:0]  grant_nxt, ack_nxt;
  logic [DATA_W-1:0]   byte_nxt;
  logic                send_nxt, err_start_nxt, err_hold_nxt;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
    return (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // First requester at or after p, walking upward with wrap; MSB flags a hit.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [IW-1:0] p);
    logic [IW:0]   res;
    logic [IW-1:0] j;
    res = '0;
    j   = p;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!res[IW] && r[j]) res = {1'b1, j};
      j = rr_next(j);
    end
    return res;
  endfunction

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    ptr_nxt       = ptr;
    last_nxt      = last_q;
    cnt_nxt       = cnt;
    grant_nxt     = grant;
    byte_nxt      = tx_byte;
    ack_nxt       = '0;
    send_nxt      = 1'b0;
    err_start_nxt = 1'b0;
    err_hold_nxt  = 1'b0;
    {pick_found, pick_idx} = rr_pick(req, ptr);
    case (state)
      IDLE: begin
        if (pick_found && tx_idle) begin
          owner_nxt = pick_idx;
          grant_nxt = onehot(pick_idx);
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        byte_nxt  = req_data[{owner, 3'b000} +: DATA_W];
        last_nxt  = req_last[owner];
        send_nxt  = 1'b1;
        ack_nxt   = onehot(owner);
        cnt_nxt   = '0;
        state_nxt = WAIT_START;
      end
      WAIT_START: begin
        if (!tx_idle) begin
          state_nxt = WAIT_DONE;
        end else if (cnt >= CW'(START_TIMEOUT - 1)) begin
          // Byte already acked to the requester: drop the packet rather than retry.
          err_start_nxt = 1'b1;
          grant_nxt     = '0;
          ptr_nxt       = rr_next(owner);
          state_nxt     = IDLE;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      WAIT_DONE: begin
        if (tx_idle) begin
          if (last_q) begin
            grant_nxt = '0;
            ptr_nxt   = rr_next(owner);
            state_nxt = IDLE;
          end else if (req[owner]) begin
            state_nxt = LOAD;
          end else begin
            cnt_nxt   = '0;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (req[owner]) begin
          state_nxt = LOAD;
        end else if (cnt >= CW'(HOLD_TIMEOUT - 1)) begin
          err_hold_nxt = 1'b1;
          grant_nxt    = '0;
          ptr_nxt      = rr_next(owner);
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      last_q    <= 1'b0;
      cnt       <= '0;
      grant     <= '0;
      req_ack   <= '0;
      tx_byte   <= '0;
      tx_send   <= 1'b0;
      busy      <= 1'b0;
      err_start <= 1'b0;
      err_hold  <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      last_q    <= last_nxt;
      cnt       <= cnt_nxt;
      grant     <= grant_nxt;
      req_ack   <= ack_nxt;
      tx_byte   <= byte_nxt;
      tx_send   <= send_nxt;
      busy      <= (state_nxt != IDLE);
      err_start <= err_start_nxt;
      err_hold  <= err_hold_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: the initial block plays both the requesters and the transmitter.
module tb_uart_tx_arbiter;
  localparam int FRAME = 6;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ack;
  logic [3:0]  grant;
  logic [7:0]  tx_byte;
  logic        tx_send;
  logic        tx_idle;
  logic        busy;
  logic        err_start;
  logic        err_hold;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] send_log[$];
  logic [3:0] ack_log[$];

  uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(16), .HOLD_TIMEOUT(4096)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .grant(grant), .tx_byte(tx_byte), .tx_send(tx_send),
    .tx_idle(tx_idle), .busy(busy), .err_start(err_start), .err_hold(err_hold)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (tx_send === 1'b1) send_log.push_back(tx_byte);
    if (req_ack !== 4'b0000) ack_log.push_back(req_ack);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req[i]            = v;
    req_data[i*8 +: 8] = d;
    req_last[i]       = l;
  endtask

  // Wait for the next send, check it, update the owner's request, then emulate one frame on the line.
  task automatic serve_byte(input string tag, input int who, input logic [7:0] b,
                            input logic nv, input logic [7:0] nd, input logic nl);
    int n;
    n = 0;
    while (tx_send !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_send"},  32'(tx_send), 32'd1);
    check({tag, "_byte"},  32'(tx_byte), 32'(b));
    check({tag, "_grant"}, 32'(grant),   32'(1) << who);
    check({tag, "_ack"},   32'(req_ack), 32'(1) << who);
    set_req(who, nv, nd, nl);
    tx_idle = 1'b0;
    repeat (FRAME) step();
    check({tag, "_hold_byte"}, 32'(tx_byte), 32'(b));
    tx_idle = 1'b1;
  endtask

  task automatic check_log(input string tag, input int idx, input logic [7:0] b, input logic [3:0] a);
    check({tag, "_lbyte"}, (idx < send_log.size()) ? 32'(send_log[idx]) : 32'hFFFF_FFFF, 32'(b));
    check({tag, "_lack"},  (idx < ack_log.size())  ? 32'(ack_log[idx])  : 32'hFFFF_FFFF, 32'(a));
  endtask

  initial begin
    int n;
    int base;
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    req_last = '0;
    tx_idle  = 1'b1;
    step();
    step();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack",   32'(req_ack), 32'd0);
    check("rst_byte",  32'(tx_byte), 32'd0);
    check("rst_send",  32'(tx_send), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_errs",  32'(err_start), 32'd0);
    check("rst_errh",  32'(err_hold), 32'd0);
    reset = 1'b0;

    // Single one-byte packet from requester 1
    base = send_log.size();
    set_req(1, 1'b1, 8'hA5, 1'b1);
    step();
    check("single_grant_early", 32'(grant), 32'd2);
    check("single_busy", 32'(busy), 32'd1);
    check("single_nosend_load", 32'(tx_send), 32'd0);
    serve_byte("single", 1, 8'hA5, 1'b0, 8'h00, 1'b0);
    step();
    check("single_release_grant", 32'(grant), 32'd0);
    check("single_release_busy", 32'(busy), 32'd0);
    repeat (3) step();
    check("single_count", 32'(send_log.size() - base), 32'd1);
    check_log("single", base, 8'hA5, 4'b0010);

    // Packet lock: requester 2 arrives mid-packet and must wait for byte 33
    base = send_log.size();
    set_req(0, 1'b1, 8'h11, 1'b0);
    serve_byte("pkt_11", 0, 8'h11, 1'b1, 8'h22, 1'b0);
    set_req(2, 1'b1, 8'h44, 1'b1);
    serve_byte("pkt_22", 0, 8'h22, 1'b1, 8'h33, 1'b1);
    serve_byte("pkt_33", 0, 8'h33, 1'b0, 8'h00, 1'b0);
    serve_byte("pkt_44", 2, 8'h44, 1'b0, 8'h00, 1'b0);
    repeat (3) step();
    check("pkt_count", 32'(send_log.size() - base), 32'd4);
    check_log("pkt0", base + 0, 8'h11, 4'b0001);
    check_log("pkt1", base + 1, 8'h22, 4'b0001);
    check_log("pkt2", base + 2, 8'h33, 4'b0001);
    check_log("pkt3", base + 3, 8'h44, 4'b0100);

    // Round-robin with all four requesting one-byte packets; reset puts the pointer at 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    base = send_log.size();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'hA0 + 8'(i), 1'b1);
    serve_byte("rr0", 0, 8'hA0, 1'b1, 8'hA0, 1'b1);
    serve_byte("rr1", 1, 8'hA1, 1'b1, 8'hA1, 1'b1);
    serve_byte("rr2", 2, 8'hA2, 1'b1, 8'hA2, 1'b1);
    serve_byte("rr3", 3, 8'hA3, 1'b1, 8'hA3, 1'b1);
    serve_byte("rr4", 0, 8'hA0, 1'b0, 8'h00, 1'b0);
    req = '0;
    repeat (4) step();
    check("rr_idle_grant", 32'(grant), 32'd0);
    check("rr_count", 32'(send_log.size() - base), 32'd5);
    check_log("rr_a", base + 0, 8'hA0, 4'b0001);
    check_log("rr_b", base + 1, 8'hA1, 4'b0010);
    check_log("rr_c", base + 2, 8'hA2, 4'b0100);
    check_log("rr_d", base + 3, 8'hA3, 4'b1000);
    check_log("rr_e", base + 4, 8'hA0, 4'b0001);

    // Start timeout: transmitter never leaves idle after the send pulse
    set_req(1, 1'b1, 8'h5A, 1'b1);
    n = 0;
    while (tx_send !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("sto_send", 32'(tx_send), 32'd1);
    check("sto_ack", 32'(req_ack), 32'd2);
    req[1] = 1'b0;
    repeat (15) step();
    check("sto_early_err", 32'(err_start), 32'd0);
    check("sto_early_grant", 32'(grant), 32'd2);
    step();
    check("sto_err", 32'(err_start), 32'd1);
    check("sto_grant", 32'(grant), 32'd0);
    check("sto_busy", 32'(busy), 32'd0);
    step();
    check("sto_err_pulse", 32'(err_start), 32'd0);
    // Pointer now 2: requester 3 wins over requester 1
    set_req(1, 1'b1, 8'hD1, 1'b1);
    set_req(3, 1'b1, 8'hD3, 1'b1);
    serve_byte("sto_ptr3", 3, 8'hD3, 1'b0, 8'h00, 1'b0);
    serve_byte("sto_ptr1", 1, 8'hD1, 1'b0, 8'h00, 1'b0);

    // Hold timeout: requester 2 sends a non-last byte then goes quiet
    set_req(2, 1'b1, 8'h77, 1'b0);
    serve_byte("hto", 2, 8'h77, 1'b0, 8'h00, 1'b0);
    set_req(0, 1'b1, 8'h88, 1'b1);
    repeat (4096) step();
    check("hto_early_err", 32'(err_hold), 32'd0);
    check("hto_locked_grant", 32'(grant), 32'd4);
    step();
    check("hto_err", 32'(err_hold), 32'd1);
    check("hto_grant", 32'(grant), 32'd0);
    step();
    check("hto_err_pulse", 32'(err_hold), 32'd0);
    serve_byte("hto_other", 0, 8'h88, 1'b0, 8'h00, 1'b0);

    // Reset during WAIT_DONE, then a fresh request set served from index 0
    set_req(1, 1'b1, 8'h3C, 1'b1);
    n = 0;
    while (tx_send !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("mrst_send", 32'(tx_send), 32'd1);
    check("mrst_grant", 32'(grant), 32'd2);
    tx_idle = 1'b0;
    step();
    step();
    base = ack_log.size();
    reset = 1'b1;
    step();
    check("mrst_grant0", 32'(grant), 32'd0);
    check("mrst_busy0", 32'(busy), 32'd0);
    check("mrst_ack0", 32'(req_ack), 32'd0);
    check("mrst_byte0", 32'(tx_byte), 32'd0);
    check("mrst_send0", 32'(tx_send), 32'd0);
    check("mrst_err0", 32'({err_start, err_hold}), 32'd0);
    reset = 1'b0;
    set_req(0, 1'b1, 8'hC3, 1'b1);
    step();
    step();
    check("mrst_wait_idle_grant", 32'(grant), 32'd0);
    check("mrst_no_ack", 32'(ack_log.size() - base), 32'd0);
    tx_idle = 1'b1;
    serve_byte("mrst_first", 0, 8'hC3, 1'b0, 8'h00, 1'b0);
    serve_byte("mrst_second", 1, 8'h3C, 1'b0, 8'h00, 1'b0);
    repeat (3) step();
    check("end_grant", 32'(grant), 32'd0);
    check("end_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
